// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: NOP encoding,
// default boot address and fetch FSM state encodings.
package fetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0]        RESET_PC_DEFAULT = 32'h0040_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_e;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid flag with
// load, hold and flush controls; flush beats hold, hold beats load.
module fetch_unit_if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               hold,
  input  logic               load,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc_plus4,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_plus4_out,
  output logic               instr_valid
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_plus4_q, pc_plus4_d;
  logic               valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush) begin
      instr_d    = NOP_INSTR;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (!hold && load) begin
      instr_d    = load_instr;
      pc_plus4_d = load_pc_plus4;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_out    = instr_q;
  assign pc_plus4_out = pc_plus4_q;
  assign instr_valid  = valid_q;

endmodule : fetch_unit_if_id_reg

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake,
// absorbs decode stalls via a one-entry hold buffer and squashes wrong-path fetches.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_plus4_out,
  output logic               instr_valid
);

  localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC) & WORD_MASK;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               req_q, req_d;
  logic               hold_valid_q, hold_valid_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0]  hold_pc4_q, hold_pc4_d;

  logic               ifid_flush, ifid_hold, ifid_load;
  logic [INSTR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0]  ifid_pc4;
  logic [ADDR_W-1:0]  pc_plus4_c;
  logic [ADDR_W-1:0]  target_c;

  assign pc_plus4_c = pc_q + ADDR_W'(4);
  assign target_c   = redirect_pc & WORD_MASK;

  // Next-state, PC, hold buffer and IF/ID control
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    ifid_flush   = 1'b0;
    ifid_hold    = 1'b0;
    ifid_load    = 1'b0;
    ifid_instr   = imem_rdata;
    ifid_pc4     = pc_plus4_c;

    case (state_q)
      ST_BOOT: begin
        ifid_hold = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect) begin
          ifid_flush   = 1'b1;
          pc_d         = target_c;
          hold_valid_d = 1'b0;
          // An unacknowledged request cannot be withdrawn, so wait it out in DROP
          state_d      = imem_ack ? ST_FETCH : ST_DROP;
        end else if (imem_ack && !stall) begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4_c;
        end else if (imem_ack) begin
          ifid_hold    = 1'b1;
          hold_valid_d = 1'b1;
          hold_instr_d = imem_rdata;
          hold_pc4_d   = pc_plus4_c;
          pc_d         = pc_plus4_c;
          state_d      = ST_HOLD;
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end else begin
          ifid_hold = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          ifid_flush   = 1'b1;
          pc_d         = target_c;
          hold_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end else if (stall) begin
          ifid_hold = 1'b1;
        end else begin
          ifid_load    = hold_valid_q;
          ifid_flush   = !hold_valid_q;
          ifid_instr   = hold_instr_q;
          ifid_pc4     = hold_pc4_q;
          hold_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          pc_d       = target_c;
        end else if (stall) begin
          ifid_hold = 1'b1;
        end else begin
          ifid_flush = 1'b1;
        end
        if (imem_ack) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // DROP keeps presenting the abandoned address until it is acknowledged
    req_d  = (state_d == ST_FETCH) || (state_d == ST_DROP);
    addr_d = (state_d == ST_DROP) ? addr_q : pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_ADDR;
      addr_q       <= RESET_ADDR;
      req_q        <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      hold_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  fetch_unit_if_id_reg #(
    .ADDR_W (ADDR_W)
  ) u_if_id_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (ifid_flush),
    .hold          (ifid_hold),
    .load          (ifid_load),
    .load_instr    (ifid_instr),
    .load_pc_plus4 (ifid_pc4),
    .instr_out     (instr_out),
    .pc_plus4_out  (pc_plus4_out),
    .instr_valid   (instr_valid)
  );

endmodule : fetch_unit

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined MIPS core.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake with variable latency.
- Drives the IF/ID pipeline register whose opcode/funct fields feed the decode-stage control logic.
- Accepts stall from the hazard logic and redirect (taken branch/jump/jr target) from decode; flushes wrong-path instructions.

Parameters:
RESET_PC, 32'h0040_0000, first fetch address after reset
ADDR_W, 32, PC/address width (word aligned, bits [1:0] always 0)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request; held high with stable imem_addr until imem_ack
imem_addr  output  ADDR_W  fetch address
imem_ack  input  1  imem_rdata valid this cycle; may assert in the same cycle as imem_req
imem_rdata  input  32  fetched instruction word
stall  input  1  hold IF/ID contents (decode cannot accept)
redirect  input  1  control transfer resolved in decode; one-cycle pulse
redirect_pc  input  ADDR_W  target address, valid with redirect
instr_out  output  32  IF/ID instruction (NOP = 32'h0000_0000 when invalid)
pc_plus4_out  output  ADDR_W  IF/ID PC+4 of instr_out
instr_valid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset values (async, rst_n=0):
  - state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC
  - instr_out=0, pc_plus4_out=0, instr_valid=0, hold buffer empty
- States: BOOT, FETCH, HOLD, DROP.
- imem_req=1 in FETCH and DROP only; imem_addr=pc in FETCH, old address in DROP. All IF/ID outputs registered.
- BOOT: one cycle after reset release, then -> FETCH. Never re-entered except by reset.
- FETCH, imem_ack=1, no stall, no redirect:
  - next edge: IF/ID <= {imem_rdata, pc+4, valid=1}; pc <= pc+4; stay FETCH.
  - Throughput: one instruction per cycle with zero-wait memory.
- FETCH, imem_ack=0, no stall: IF/ID <= bubble (instr 0, valid 0); pc unchanged.
- FETCH, imem_ack=1, stall=1: IF/ID unchanged; word and pc+4 captured into hold buffer; pc <= pc+4; -> HOLD.
- FETCH, imem_ack=0, stall=1: IF/ID unchanged; keep requesting.
- HOLD: imem_req=0.
  - While stall=1: IF/ID and buffer unchanged.
  - When stall=0: IF/ID <= buffer, buffer emptied, -> FETCH.
- Redirect has priority over stall and ack:
  - Next edge: IF/ID <= bubble; pc <= redirect_pc; buffer emptied.
  - From FETCH with imem_ack=1 or from HOLD: -> FETCH.
  - From FETCH with imem_ack=0: -> DROP. The outstanding request must complete; the handshake may not be withdrawn.
- DROP: imem_req=1, imem_addr=old address.
  - On imem_ack: discard word, -> FETCH (new pc).
  - Second redirect in DROP: overwrite pc, stay DROP.
- stall during DROP/BOOT: IF/ID held unchanged.
- pc arithmetic: modulo 2^ADDR_W. 32'hFFFF_FFFC+4 wraps to 0 silently. redirect_pc[1:0] ignored (forced 0).
- Reset mid-transaction: everything returns to reset values immediately; a late imem_ack after reset is ignored (state BOOT/FETCH treat it per rules above only when imem_req=1).
- Invariant: imem_req never falls while a request is unacknowledged; imem_addr stable while imem_req=1 and imem_ack=0.

Decomposition:
- Shared header (mips.h): NOP encoding, RESET_PC default, fetch state encodings (2-bit).
- Natural sub-module: if_id_reg. Holds instr/pc_plus4/valid with load, hold (stall) and flush (bubble) controls; flush wins over hold.
- FSM and PC live in fetch_unit.

Test Plan:
- Reset release, zero-wait ack every cycle: addresses 0x00400000, 0x00400004, 0x00400008 on consecutive cycles. instr_valid=1 from 2nd cycle after BOOT; pc_plus4_out=0x00400004 with first word.
- Ack after 3-cycle latency: imem_addr held at 0x00400000 for 3 cycles with req=1; instr_valid=0 bubbles meanwhile; then word appears once.
- stall=1 for 4 cycles while ack arrives: IF/ID frozen; imem_req=0 in HOLD. On stall=0, buffered word enters IF/ID next edge, no instruction lost or duplicated.
- redirect to 0x00400100 with pending unacked request at 0x00400010: FSM in DROP; req stays on 0x00400010 until ack. Word discarded, instr_valid=0; next request is 0x00400100.
- redirect and stall asserted together with valid IF/ID: IF/ID flushed (instr_out=0, valid=0); pc=redirect_pc.
- rst_n pulsed low mid-DROP: outputs return to reset values asynchronously; first post-reset request is RESET_PC; pc wrap test 0xFFFFFFFC -> 0x00000000.
